// File: rtl/seq_neuron_mac_pkg.sv
// seq_neuron_mac_pkg: FSM encodings, activation codes and sign-magnitude helpers shared by the neuron layers
package seq_neuron_mac_pkg;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    localparam int ACT_RELU  = 0;
    localparam int ACT_IDENT = 1;

    typedef struct packed {
        logic        sign;
        logic [62:0] mag;
    } sm_t;

    // w-bit sign-magnitude (zero-extended into 64 bits) to 64-bit two's complement; -0 maps to 0
    function automatic logic signed [63:0] sm2tc(input logic [63:0] sm, input int w);
        logic [63:0] mag;
        mag = sm & ((64'd1 << (w - 1)) - 64'd1);
        return sm[6'(w - 1)] ? -$signed(mag) : $signed(mag);
    endfunction

    // two's complement (sign-extended to 64 bits) to sign + magnitude
    function automatic sm_t tc2sm(input logic signed [63:0] v);
        return '{sign: v[63], mag: 63'(v[63] ? -v : v)};
    endfunction
endpackage

// File: rtl/seq_neuron_mac_if.sv
// seq_neuron_mac_if: control, pair stream and result stream of one sequential neuron
interface seq_neuron_mac_if #(parameter int DW = 8);
    logic          start;
    logic          abort;
    logic [DW-1:0] bias;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x;
    logic [DW-1:0] w;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] y;
    logic          busy;

    modport master (
        output start, abort, bias, in_valid, x, w, out_ready,
        input  in_ready, out_valid, y, busy
    );
    modport slave (
        input  start, abort, bias, in_valid, x, w, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/seq_neuron_mac_sm_rescale_sat.sv
// seq_neuron_mac_sm_rescale_sat: accumulator to DW-bit sign-magnitude with rescale, saturation and -0 cleanup
module seq_neuron_mac_sm_rescale_sat
    import seq_neuron_mac_pkg::*;
#(
    parameter int ACC_W = 18,
    parameter int DW    = 8,
    parameter int SHIFT = 7
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic        [DW-1:0]    o_y
);
    sm_t         w_sm;
    logic [62:0] w_shr;
    logic        w_sat;
    logic [DW-2:0] w_mag;

    // truncate magnitude toward zero, clamp to full scale, never emit negative zero
    always_comb begin
        w_sm  = tc2sm(64'(i_acc));
        w_shr = w_sm.mag >> SHIFT;
        w_sat = w_shr >= (63'd1 << (DW - 1));
        w_mag = w_sat ? '1 : w_shr[DW-2:0];
        o_y   = {w_sm.sign && (w_mag != '0), w_mag};
    end
endmodule

// File: rtl/seq_neuron_mac.sv
// seq_neuron_mac: time-multiplexed neuron, one sign-magnitude x*w pair per clock into a wide accumulator
module seq_neuron_mac
    import seq_neuron_mac_pkg::*;
#(
    parameter int DW    = 8,
    parameter int N_IN  = 16,
    parameter int SHIFT = 7,
    parameter int ACT   = ACT_RELU
) (
    input logic             clk,
    input logic             rst_n,
    seq_neuron_mac_if.slave bus
);
    localparam int ACC_W = 2 * DW - 1 + $clog2(N_IN) + 1;
    localparam int CW    = $clog2(N_IN) > 0 ? $clog2(N_IN) : 1;

    logic [1:0]              r_state;
    logic [CW-1:0]           r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic [DW-1:0]           r_y;

    logic [2*DW-3:0]         w_pmag;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_bias;
    logic [DW-1:0]           w_y_sat;
    logic [DW-1:0]           w_y_act;
    logic                    w_xfer;

    assign bus.in_ready  = r_state == S_ACCUM;
    assign bus.out_valid = r_state == S_OUT;
    assign bus.busy      = r_state != S_IDLE;
    assign bus.y         = r_y;
    assign w_xfer        = bus.in_valid && bus.in_ready;

    // signed product and pre-scaled bias in accumulator format
    always_comb begin
        w_pmag  = bus.x[DW-2:0] * bus.w[DW-2:0];
        w_prod  = ACC_W'(sm2tc(64'({bus.x[DW-1] ^ bus.w[DW-1], w_pmag}), 2 * DW - 1));
        w_bias  = ACC_W'(sm2tc(64'(bus.bias), DW)) <<< SHIFT;
        w_y_act = (ACT == ACT_RELU && w_y_sat[DW-1]) ? '0 : w_y_sat;
    end

    seq_neuron_mac_sm_rescale_sat #(.ACC_W(ACC_W), .DW(DW), .SHIFT(SHIFT)) u_sat (
        .i_acc (r_acc),
        .o_y   (w_y_sat)
    );

    // FSM, pair counter and accumulator; abort overrides everything else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_y     <= '0;
        end else if (bus.abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_acc   <= w_bias;
                    r_cnt   <= '0;
                    r_state <= S_ACCUM;
                end
                S_ACCUM: if (w_xfer) begin
                    r_acc <= r_acc + w_prod;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N_IN - 1)) r_state <= S_FINISH;
                end
                S_FINISH: begin
                    r_y     <= w_y_act;
                    r_state <= S_OUT;
                end
                S_OUT: if (bus.out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_neuron_mac.sv
// tb_seq_neuron_mac: directed checks of a ReLU and an identity neuron driven side by side
module tb_seq_neuron_mac;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] bias = 8'h00;
    logic [7:0] x = 8'h00;
    logic [7:0] w = 8'h00;
    int         checks = 0;
    int         errors = 0;
    logic [15:0] sb[$];

    seq_neuron_mac_if #(.DW(8)) if0 ();
    seq_neuron_mac_if #(.DW(8)) if1 ();

    assign if0.start = start;
    assign if0.abort = abort;
    assign if0.bias = bias;
    assign if0.in_valid = in_valid;
    assign if0.x = x;
    assign if0.w = w;
    assign if0.out_ready = out_ready;
    assign if1.start = start;
    assign if1.abort = abort;
    assign if1.bias = bias;
    assign if1.in_valid = in_valid;
    assign if1.x = x;
    assign if1.w = w;
    assign if1.out_ready = out_ready;

    seq_neuron_mac #(.DW(8), .N_IN(4), .SHIFT(7), .ACT(0)) u_relu (.clk(clk), .rst_n(rst_n), .bus(if0));
    seq_neuron_mac #(.DW(8), .N_IN(4), .SHIFT(7), .ACT(1)) u_ident (.clk(clk), .rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] y0, input logic [7:0] y1);
        chk({tag, " ctl0"}, {13'd0, if0.in_ready, if0.out_valid, if0.busy}, 16'd0);
        chk({tag, " ctl1"}, {13'd0, if1.in_ready, if1.out_valid, if1.busy}, 16'd0);
        chk({tag, " y"}, {if0.y, if1.y}, {y0, y1});
    endtask

    // one evaluation: pairs packed MSB-first, optional random gaps with start held high, stall cycles on out_ready
    task automatic run(input string tag, input logic [7:0] b, input logic [31:0] xs, input logic [31:0] ws,
                       input bit gaps, input int stall, input logic [7:0] e0, input logic [7:0] e1);
        logic [15:0] e;
        int n;
        sb.push_back({e0, e1});
        start = 1'b1;
        bias = b;
        tick();
        start = gaps;
        chk({tag, " busy"}, {14'd0, if0.busy, if1.busy}, 16'h0003);
        for (int i = 0; i < 4; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                x = 8'h7F;
                w = 8'h7F;
                tick();
            end
            in_valid = 1'b1;
            x = xs[31-8*i -: 8];
            w = ws[31-8*i -: 8];
            if (i == 3) start = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        n = 1;
        while (!if0.out_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 16'(n), 16'd2);
        for (int i = 0; i < stall; i++) begin
            chk({tag, " stall"}, {6'd0, if0.out_valid, if1.out_valid, if0.y, if1.y}, {8'h03, e0, e1});
            tick();
        end
        e = sb.pop_front();
        chk({tag, " y"}, {if0.y, if1.y}, e);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_idle({tag, " done"}, e0, e1);
    endtask

    initial begin
        tick();
        tick();
        chk_idle("reset", 8'h00, 8'h00);
        rst_n = 1'b1;
        tick();
        run("bias", 8'h05, 32'h0, 32'h0, 1'b0, 0, 8'h05, 8'h05);
        run("mac", 8'h00, 32'h40000000, 32'h407F7F7F, 1'b0, 0, 8'h20, 8'h20);
        run("negzero", 8'h00, 32'h80000000, 32'h407F7F7F, 1'b0, 0, 8'h00, 8'h00);
        run("sat", 8'h00, 32'h40404040, 32'h40404040, 1'b0, 0, 8'h7F, 8'h7F);
        run("satneg", 8'h00, 32'hC0C0C0C0, 32'h40404040, 1'b0, 0, 8'h00, 8'hFF);
        run("act", 8'h00, 32'hC0000000, 32'h40000000, 1'b0, 0, 8'h00, 8'hA0);
        run("biasneg", 8'h85, 32'h40000000, 32'h40000000, 1'b0, 0, 8'h1B, 8'h1B);
        run("biasnz", 8'h80, 32'h0, 32'h0, 1'b0, 1, 8'h00, 8'h00);
        run("hs", 8'h00, 32'h40000000, 32'h407F7F7F, 1'b1, 5, 8'h20, 8'h20);
        start = 1'b1;
        bias = 8'h7F;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        x = 8'h40;
        w = 8'h40;
        tick();
        tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        chk_idle("abort", 8'h20, 8'h20);
        run("postabort", 8'h00, 32'h40000000, 32'h407F7F7F, 1'b0, 0, 8'h20, 8'h20);
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rstmid", 8'h00, 8'h00);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run("postrst", 8'h05, 32'h0, 32'h0, 1'b0, 0, 8'h05, 8'h05);
        chk("sb empty", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
